seq_mult_param: RTL and testbench

Parametrised sequential shift-add multiplier supporting unsigned and two's-complement signed operands, selected per operation. It is the next-generation arithmetic building block for the multiplier family. It adds a width parameter, signed mode, and an explicit busy/done handshake. Intended for datapaths where area matters more than throughput: one operand bit per cycle.

---
 rtl/seq_mult_pkg.sv | 26 ++
 rtl/twos_neg.sv | 19 +
 rtl/seq_mult_param.sv | 161 ++++++++++++++++
 tb/tb_seq_mult_param.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/seq_mult_pkg.sv
// Shared definitions for the sequential shift-add multiplier family:
// FSM state encoding, operand mode constants and the counter-width helper.
package seq_mult_pkg;

    // Control states of the multiplier sequencer.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    // Values of the per-operation sign_mode input.
    localparam logic MODE_UNSIGNED = 1'b0;
    localparam logic MODE_SIGNED   = 1'b1;

    // Bits needed to count from 0 to width-1 (ceil(log2(width)), minimum 1).
    function automatic int cnt_width(input int width);
        int r;
        r = 1;
        while ((1 << r) < width) begin
            r = r + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/twos_neg.sv
// Parametrised combinational conditional negate: out = en ? -in : in
// (two's complement, result truncated to W bits).
module twos_neg #(
    parameter int W = 6
) (
    input  logic [W-1:0] in_val,
    input  logic         en,
    output logic [W-1:0] out_val
);

    // Invert-and-increment when enabled, pass-through otherwise.
    always_comb begin
        out_val = in_val;
        if (en) begin
            out_val = ~in_val + W'(1);
        end
    end

endmodule

// File: rtl/seq_mult_param.sv
// Sequential shift-add multiplier, one multiplier bit per cycle.
// Signed operands are converted to magnitudes on accept; the unsigned
// magnitude product is accumulated and negated on the final RUN edge when
// the operand signs differ.
//
// Handshake: an operation is accepted on a rising edge where load=1 and the
// FSM is in IDLE or DONE (load in RUN is ignored, nothing is queued). busy is
// high in RUN and DONE; done is high for exactly the one DONE cycle, and
// product is valid from that cycle until the next completion.
module seq_mult_param
    import seq_mult_pkg::*;
#(
    parameter int WIDTH = 6
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 load,
    input  logic                 sign_mode,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic [2*WIDTH-1:0]   product,
    output logic                 busy,
    output logic                 done
);

    localparam int CW = cnt_width(WIDTH);
    localparam int PW = 2 * WIDTH;
    localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

    // Registered state
    state_e             state_q,   state_d;
    logic [CW-1:0]      cnt_q,     cnt_d;
    logic [PW-1:0]      acc_q,     acc_d;
    logic [WIDTH-1:0]   mag_a_q,   mag_a_d;
    logic [WIDTH-1:0]   mag_b_q,   mag_b_d;
    logic               sa_q,      sa_d;
    logic               sb_q,      sb_d;
    logic               mode_q,    mode_d;
    logic [PW-1:0]      product_q, product_d;

    // Operand-side signals (accept path)
    logic               sa_in;
    logic               sb_in;
    logic [WIDTH-1:0]   mag_a_in;
    logic [WIDTH-1:0]   mag_b_in;

    // Datapath signals (RUN path)
    logic [PW-1:0]      term;
    logic [PW-1:0]      acc_sum;
    logic               neg_res;
    logic [PW-1:0]      result;

    // Operand signs only exist in signed mode.
    assign sa_in = a[WIDTH-1] & sign_mode;
    assign sb_in = b[WIDTH-1] & sign_mode;

    // |a| and |b| as WIDTH-bit unsigned values; -2^(W-1) maps onto 2^(W-1).
    twos_neg #(.W(WIDTH)) u_neg_a (
        .in_val  (a),
        .en      (sa_in),
        .out_val (mag_a_in)
    );

    twos_neg #(.W(WIDTH)) u_neg_b (
        .in_val  (b),
        .en      (sb_in),
        .out_val (mag_b_in)
    );

    // Partial product for the current multiplier bit and the running sum.
    always_comb begin
        term = '0;
        if (mag_b_q[cnt_q]) begin
            term = {{WIDTH{1'b0}}, mag_a_q} << cnt_q;
        end
        acc_sum = acc_q + term;
        neg_res = (mode_q == MODE_SIGNED) && (sa_q ^ sb_q);
    end

    // Apply the result sign to the completed magnitude product.
    twos_neg #(.W(PW)) u_neg_p (
        .in_val  (acc_sum),
        .en      (neg_res),
        .out_val (result)
    );

    // Next-state logic for the FSM, counter, accumulator and operand registers.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        acc_d     = acc_q;
        mag_a_d   = mag_a_q;
        mag_b_d   = mag_b_q;
        sa_d      = sa_q;
        sb_d      = sb_q;
        mode_d    = mode_q;
        product_d = product_q;

        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (load) begin
                    // Accept: capture operands and start a fresh accumulation.
                    state_d = ST_RUN;
                    mode_d  = sign_mode;
                    sa_d    = sa_in;
                    sb_d    = sb_in;
                    mag_a_d = mag_a_in;
                    mag_b_d = mag_b_in;
                    acc_d   = '0;
                    cnt_d   = '0;
                end else begin
                    state_d = ST_IDLE;
                end
            end

            ST_RUN: begin
                acc_d = acc_sum;
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == LAST_CNT) begin
                    product_d = result;
                    state_d   = ST_DONE;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State registers with asynchronous reset; reset aborts any operation.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            acc_q     <= '0;
            mag_a_q   <= '0;
            mag_b_q   <= '0;
            sa_q      <= 1'b0;
            sb_q      <= 1'b0;
            mode_q    <= MODE_UNSIGNED;
            product_q <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            acc_q     <= acc_d;
            mag_a_q   <= mag_a_d;
            mag_b_q   <= mag_b_d;
            sa_q      <= sa_d;
            sb_q      <= sb_d;
            mode_q    <= mode_d;
            product_q <= product_d;
        end
    end

    // Status outputs decoded directly from the state register.
    assign busy    = (state_q != ST_IDLE);
    assign done    = (state_q == ST_DONE);
    assign product = product_q;

endmodule

// File: tb/tb_seq_mult_param.sv
// Bench for seq_mult_param: a WIDTH=6 and a WIDTH=16 instance driven by
// directed and random operations, checked against an arithmetic model.
module tb_seq_mult_param;

    // Clock and reset
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    // WIDTH=6 instance
    logic        load6, sm6;
    logic [5:0]  a6, b6;
    logic [11:0] product6;
    logic        busy6, done6;

    // WIDTH=16 instance
    logic        load16, sm16;
    logic [15:0] a16, b16;
    logic [31:0] product16;
    logic        busy16, done16;

    seq_mult_param #(.WIDTH(6)) dut6 (
        .clk       (clk),
        .rst       (rst),
        .load      (load6),
        .sign_mode (sm6),
        .a         (a6),
        .b         (b6),
        .product   (product6),
        .busy      (busy6),
        .done      (done6)
    );

    seq_mult_param #(.WIDTH(16)) dut16 (
        .clk       (clk),
        .rst       (rst),
        .load      (load16),
        .sign_mode (sm16),
        .a         (a16),
        .b         (b16),
        .product   (product16),
        .busy      (busy16),
        .done      (done16)
    );

    int checks = 0;
    int errors = 0;

    // Last result the model expects each instance to be holding.
    logic [63:0] last6  = '0;
    logic [63:0] last16 = '0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference: interpret operands as integers, multiply, keep 2*w bits.
    function automatic logic [63:0] ref_mul(input int w, input logic [31:0] a,
                                            input logic [31:0] b, input bit s);
        longint unsigned mask_w;
        longint unsigned mask_p;
        longint av;
        longint bv;
        longint unsigned p;
        mask_w = (64'd1 << w) - 64'd1;
        mask_p = (64'd1 << (2 * w)) - 64'd1;
        av = longint'({32'd0, a} & mask_w);
        bv = longint'({32'd0, b} & mask_w);
        if (s && a[w-1]) av = av - longint'(64'd1 << w);
        if (s && b[w-1]) bv = bv - longint'(64'd1 << w);
        p = longint'(av * bv);
        return p & mask_p;
    endfunction

    function automatic logic get_busy(input int w);
        return (w == 6) ? busy6 : busy16;
    endfunction

    function automatic logic get_done(input int w);
        return (w == 6) ? done6 : done16;
    endfunction

    function automatic logic [63:0] get_prod(input int w);
        return (w == 6) ? {52'd0, product6} : {32'd0, product16};
    endfunction

    // Driver: put operands and load on the selected instance.
    task automatic drive_ops(input int w, input logic [31:0] a, input logic [31:0] b,
                             input logic s, input logic l);
        if (w == 6) begin
            a6 = a[5:0]; b6 = b[5:0]; sm6 = s; load6 = l;
        end else begin
            a16 = a[15:0]; b16 = b[15:0]; sm16 = s; load16 = l;
        end
    endtask

    // Present an operation, let the accept edge pass, then scramble the
    // operands (they must no longer matter). Returns #1 after the accept edge.
    task automatic start(input int w, input logic [31:0] a, input logic [31:0] b, input logic s);
        @(negedge clk);
        drive_ops(w, a, b, s, 1'b1);
        @(posedge clk);
        #1;
        drive_ops(w, $urandom, $urandom, 1'($urandom_range(0, 1)), 1'b0);
    endtask

    // Wait (bounded) for done; n0 = cycles already elapsed since accept.
    task automatic wait_done(input int w, input string tag, input logic [63:0] exp_p,
                             input logic [63:0] prev_p, input int n0);
        int n;
        bit held;
        bit stayed_busy;
        n = n0;
        held = 1'b1;
        stayed_busy = 1'b1;
        while (!get_done(w) && n < w + 8) begin
            if (get_prod(w) !== prev_p) held = 1'b0;
            if (!get_busy(w)) stayed_busy = 1'b0;
            @(posedge clk);
            #1;
            n++;
        end
        chk({tag, "_done"}, 64'(get_done(w)), 64'd1);
        chk({tag, "_latency"}, 64'(n), 64'(w));
        chk({tag, "_hold"}, 64'(held), 64'd1);
        chk({tag, "_busy_run"}, 64'(stayed_busy), 64'd1);
        chk({tag, "_busy_done"}, 64'(get_busy(w)), 64'd1);
        chk({tag, "_product"}, get_prod(w), exp_p);
    endtask

    // One isolated operation followed by a return to IDLE.
    task automatic do_op(input int w, input logic [31:0] a, input logic [31:0] b,
                         input logic s, input logic [63:0] exp_p, input string tag);
        logic [63:0] prev;
        prev = (w == 6) ? last6 : last16;
        start(w, a, b, s);
        wait_done(w, tag, exp_p, prev, 0);
        if (w == 6) last6 = exp_p; else last16 = exp_p;
        @(posedge clk);
        #1;
        chk({tag, "_done_pulse"}, 64'(get_done(w)), 64'd0);
        chk({tag, "_idle"}, 64'(get_busy(w)), 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] ra, rb;
        logic        rs;
        logic [63:0] e1, e2;

        // Reset
        rst = 1'b1;
        drive_ops(6, 0, 0, 1'b0, 1'b0);
        drive_ops(16, 0, 0, 1'b0, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        chk("rst_product6", {52'd0, product6}, 64'd0);
        chk("rst_busy6", 64'(busy6), 64'd0);
        chk("rst_done6", 64'(done6), 64'd0);
        chk("rst_product16", {32'd0, product16}, 64'd0);
        chk("rst_busy16", 64'(busy16), 64'd0);
        @(negedge clk);
        rst = 1'b0;

        // Directed values
        do_op(6, 63, 63, 1'b0, 64'd3969, "u63x63");
        do_op(6, 6'h3f, 6'h3f, 1'b1, 64'h001, "s_m1xm1");
        do_op(6, 6'h20, 6'h20, 1'b1, 64'h400, "s_m32xm32");
        do_op(6, 6'h20, 6'h1f, 1'b1, 64'hC20, "s_m32x31");
        do_op(6, 6'h00, 6'h20, 1'b1, 64'h000, "s_0xm32");
        do_op(6, 6'h20, 6'h20, 1'b0, 64'd1024, "u32x32");

        // load pulsed mid-RUN with other operands: ignored, not queued
        start(6, 13, 11, 1'b0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        drive_ops(6, 50, 60, 1'b1, 1'b1);
        @(posedge clk);
        #1;
        drive_ops(6, 0, 0, 1'b0, 1'b0);
        wait_done(6, "midrun", 64'd143, last6, 3);
        last6 = 64'd143;
        @(posedge clk);
        #1;
        chk("midrun_no_queue", 64'(busy6), 64'd0);

        // Back-to-back via DONE with load held through the DONE cycle
        e1 = ref_mul(6, 6'h2b, 6'h15, 1'b1);
        start(6, 6'h2b, 6'h15, 1'b1);
        wait_done(6, "b2b_first", e1, last6, 0);
        last6 = e1;
        for (int i = 0; i < 5; i++) begin
            ra = $urandom; rb = $urandom; rs = 1'($urandom_range(0, 1));
            e2 = ref_mul(6, ra, rb, rs);
            drive_ops(6, ra, rb, rs, 1'b1);
            @(posedge clk);
            #1;
            drive_ops(6, $urandom, $urandom, 1'b0, 1'b0);
            wait_done(6, "b2b_next", e2, last6, 0);
            last6 = e2;
        end
        @(posedge clk);
        #1;
        chk("b2b_end_idle", 64'(busy6), 64'd0);

        // Random isolated operations at WIDTH=6
        for (int i = 0; i < 20; i++) begin
            ra = $urandom; rb = $urandom; rs = 1'($urandom_range(0, 1));
            do_op(6, ra, rb, rs, ref_mul(6, ra, rb, rs), "rand6");
        end

        // Asynchronous reset three cycles into RUN
        start(6, 63, 63, 1'b0);
        repeat (3) @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        chk("arst_busy", 64'(busy6), 64'd0);
        chk("arst_done", 64'(done6), 64'd0);
        chk("arst_product", {52'd0, product6}, 64'd0);
        chk("arst_product16", {32'd0, product16}, 64'd0);
        @(negedge clk);
        rst = 1'b0;
        last6 = '0;
        last16 = '0;
        do_op(6, 5, 7, 1'b0, 64'd35, "after_rst_5x7");

        // WIDTH=16 instance
        do_op(16, 16'h8000, 16'h8000, 1'b1, 64'h40000000, "w16_m32768sq");
        do_op(16, 16'hffff, 16'hffff, 1'b0, 64'hfffe0001, "w16_umax");
        for (int i = 0; i < 8; i++) begin
            ra = $urandom; rb = $urandom; rs = 1'($urandom_range(0, 1));
            do_op(16, ra, rb, rs, ref_mul(16, ra, rb, rs), "rand16");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
